aes_inv_round_engine: RTL and testbench
=======================================

# aes_inv_round_engine

Iterative AES inverse-cipher engine: accepts one 128-bit ciphertext block over a valid/ready handshake and applies the FIPS-197 inverse rounds, one round per clock. It produces the plaintext on a valid/ready output. It is the decrypt-direction counterpart of the forward round datapath. Round keys are loaded beforehand through a dedicated write port; key expansion is done elsewhere.

## Interface
- NR, default 10: number of cipher rounds; legal values 10, 12, 14 (AES-128/192/256).
- CLK  in  1  sole clock, all state updates on rising edge.
- RST  in  1  reset, synchronous and active-high.
- KEY_WE  in  1  round-key write strobe.
- KEY_IDX  in  4  round-key index, 0..NR.
- KEY_DATA  in  128  round key w[4i..4i+3], byte 0 in [127:120].
- IN_VALID  in  1  ciphertext offered.
- IN_READY  out  1  engine can accept a ciphertext.
- IN_DATA  in  128  ciphertext, byte 0 in [127:120].
- OUT_VALID  out  1  plaintext available.
- OUT_READY  in  1  consumer takes plaintext.
- OUT_DATA  out  128  plaintext.
- BUSY  out  1  high in ROUND and DONE.

## Operation
- State layout follows FIPS-197: byte k = bits [127-8k -: 8], s[r][c] = byte 4c+r.
- Round-key file: NR+1 × 128-bit registers, not cleared by RST.
  - Write on KEY_WE only when the FSM is IDLE and KEY_IDX ≤ NR.
  - Writes in other states, or with KEY_IDX > NR, are silently dropped.
- FSM states: IDLE, ROUND, DONE; 4-bit round counter CNT.
- **IDLE**: IN_READY=1.
  - On IN_VALID & IN_READY: STATE ← IN_DATA ^ rk[NR], CNT ← NR-1, go to ROUND.
- **ROUND**: each cycle, T = InvSubBytes(InvShiftRows(STATE)) ^ rk[CNT].
  - If CNT≠0: STATE ← InvMixColumns(T), CNT ← CNT-1.
  - If CNT=0: STATE ← T, go to DONE.
- **DONE**: OUT_VALID=1, OUT_DATA=STATE, held stable until OUT_READY. On OUT_READY, go to IDLE.
- IN_READY=0 in ROUND and DONE; no overlap of blocks.
- InvShiftRows: row r rotated right by r bytes.
- InvSubBytes: inverse S-box per byte.
- InvMixColumns: per column, matrix rows {0e,0b,0d,09} circulant, GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
- OUT_DATA is driven from STATE in all states. It is only meaningful while OUT_VALID=1.

## Timing
- Reset values: IN_READY=0 during the RST cycle, 1 from the first cycle after RST deasserts; OUT_VALID=0; OUT_DATA=0; BUSY=0; FSM=IDLE; CNT=0.
- Latency:
  - Accepting edge E0.
  - Rounds complete on edges E1..E_NR.
  - OUT_VALID is high in the cycle after E_NR, i.e. NR edges after acceptance.
- Throughput: minimum NR+2 cycles per block (NR rounds, ≥1 DONE cycle, 1 IDLE cycle).
- Simultaneous KEY_WE and accepted IN_VALID in IDLE:
  - The key write lands at the same edge.
  - The initial AddRoundKey uses the pre-edge rk[NR].
  - The new value is used by all later rounds.
- OUT_READY high while OUT_VALID=0 has no effect.
- IN_VALID outside IDLE is ignored; the producer must hold it.
- RST asserted in any state aborts the block at that edge: FSM→IDLE, OUT_VALID=0, BUSY=0, no partial result emitted. The key file is retained.
- RST has priority over every other input in the same cycle.

## Test plan
- **FIPS-197 C.1, NR=10**
  - Stimulus: load rk[0..10] expanded from 000102030405060708090a0b0c0d0e0f (rk[10]=13111d7fe3944a17f307a78b4d2b30c5), then send 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: OUT_DATA=00112233445566778899aabbccddeeff, OUT_VALID exactly 10 edges after acceptance, BUSY high throughout.
- **FIPS-197 Appendix B**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32.
  - Required: plaintext 3243f6a8885a308d313198a2e0370734.
- **Backpressure**
  - Stimulus: hold OUT_READY=0 for 5 cycles after OUT_VALID; keep IN_VALID=1 with a second block.
  - Required: OUT_DATA stable, IN_READY=0, second block not accepted until the cycle after the OUT_READY handshake. Second block then decrypts correctly.
- **Reset mid-operation**
  - Stimulus: assert RST when CNT=5.
  - Required: no OUT_VALID, BUSY=0 after the edge, IN_READY=1 after release. The C.1 decrypt repeated without reloading keys yields 00112233445566778899aabbccddeeff.
- **Illegal key writes**
  - Stimulus: KEY_WE with KEY_DATA=all-ones to index 3 during ROUND; KEY_IDX=15 in IDLE.
  - Required: both dropped; the C.1 result is unchanged.
- **NR=14, FIPS-197 C.3**
  - Stimulus: keys from 000102…1e1f, ciphertext 8ea2b7ca516745bfeafc49904b496089.
  - Required: 00112233445566778899aabbccddeeff, 14-edge latency.

Source files
------------

// File: rtl/aes_inv_round_engine.sv
// Iterative AES inverse cipher: one FIPS-197 inverse round per clock, round keys
// held in a local register file written through a dedicated port.
module aes_inv_round_engine #(
    parameter int NR = 10
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         KEY_WE,
    input  logic [3:0]   KEY_IDX,
    input  logic [127:0] KEY_DATA,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] OUT_DATA,
    output logic         BUSY
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // First row of the InvMixColumns circulant: 0e, 0b, 0d, 09.
    localparam logic [3:0] IMC [0:3] = '{4'he, 4'hb, 4'hd, 4'h9};

    fsm_t         fsm_q, fsm_d;
    logic [127:0] data_q;
    logic [3:0]   cnt_q;
    logic [127:0] rk [0:NR];
    logic [127:0] round_t;
    logic [127:0] round_out;
    logic         accept;
    logic         key_wr;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant via x, 2x, 4x, 8x partial products.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return (k[3] ? a8 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^ (k[1] ? a2 : 8'h00) ^ (k[0] ? a : 8'h00);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        logic [1:0]   src_c;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src_c = 2'(c - r);
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * int'(src_c) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127 - 8 * i -: 8] = INV_SBOX[s[127 - 8 * i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc ^= gf_mul(s[127 - 8 * (4 * c + k) -: 8], IMC[2'(k - r)]);
                o[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    assign accept    = (fsm_q == IDLE) && IN_VALID;
    assign key_wr    = KEY_WE && !RST && (fsm_q == IDLE) && (KEY_IDX <= 4'(NR));
    assign round_t   = inv_sub_bytes(inv_shift_rows(data_q)) ^ rk[cnt_q];
    assign round_out = (cnt_q == 4'd0) ? round_t : inv_mix_columns(round_t);

    // NOTE: the key file has no reset; keys survive RST and a plain register array maps to cheaper storage.
    always_ff @(posedge CLK) begin
        if (key_wr)
            rk[KEY_IDX] <= KEY_DATA;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values, e.g. rk[NR] on the accept edge.
    always_ff @(posedge CLK) begin
        if (RST)
            fsm_q <= IDLE;
        else
            fsm_q <= fsm_d;
    end

    // NOTE: fsm_d is defaulted first so no path through the case can infer a latch.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (IN_VALID) fsm_d = ROUND;
            ROUND:   if (cnt_q == 4'd0) fsm_d = DONE;
            DONE:    if (OUT_READY) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = (fsm_q == IDLE) && !RST;
        OUT_VALID = (fsm_q == DONE) && !RST;
        BUSY      = (fsm_q != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            data_q <= IN_DATA ^ rk[NR];
            cnt_q  <= 4'(NR - 1);
        end else if (fsm_q == ROUND) begin
            data_q <= round_out;
            if (cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
        end
    end

    assign OUT_DATA = data_q;

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Directed bench for aes_inv_round_engine: FIPS-197 vectors at NR=10 and NR=14,
// with round keys expanded by a local reference key schedule.
module tb_aes_inv_round_engine;

    typedef struct {
        string        name;
        logic         sel;
        int           nk;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_STD = 128'h00112233445566778899aabbccddeeff;

    logic         CLK;
    logic         RST;
    logic         KEY_WE;
    logic [3:0]   KEY_IDX;
    logic [127:0] KEY_DATA;
    logic [127:0] IN_DATA;
    logic         OUT_READY;
    logic         in_valid;
    logic         sel;

    logic         in_valid_a, in_ready_a, out_valid_a, busy_a;
    logic         in_valid_b, in_ready_b, out_valid_b, busy_b;
    logic [127:0] out_data_a, out_data_b;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sbox [0:255];
    logic [31:0]  w    [0:63];
    logic [127:0] rks  [0:15];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign in_valid_a = in_valid && !sel;
    assign in_valid_b = in_valid && sel;
    assign in_ready   = sel ? in_ready_b  : in_ready_a;
    assign out_valid  = sel ? out_valid_b : out_valid_a;
    assign busy       = sel ? busy_b      : busy_a;
    assign out_data   = sel ? out_data_b  : out_data_a;

    aes_inv_round_engine #(.NR(10)) u_dut10 (
        .CLK(CLK), .RST(RST), .KEY_WE(KEY_WE), .KEY_IDX(KEY_IDX), .KEY_DATA(KEY_DATA),
        .IN_VALID(in_valid_a), .IN_READY(in_ready_a), .IN_DATA(IN_DATA),
        .OUT_VALID(out_valid_a), .OUT_READY(OUT_READY), .OUT_DATA(out_data_a), .BUSY(busy_a)
    );

    aes_inv_round_engine #(.NR(14)) u_dut14 (
        .CLK(CLK), .RST(RST), .KEY_WE(KEY_WE), .KEY_IDX(KEY_IDX), .KEY_DATA(KEY_DATA),
        .IN_VALID(in_valid_b), .IN_READY(in_ready_b), .IN_DATA(IN_DATA),
        .OUT_VALID(out_valid_b), .OUT_READY(OUT_READY), .OUT_DATA(out_data_b), .BUSY(busy_b)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // Forward S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[8'(x)] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++)
            w[6'(i)] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[6'(i - 1)];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[6'(i)] = w[6'(i - nk)] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            rks[4'(r)] = {w[6'(4 * r)], w[6'(4 * r + 1)], w[6'(4 * r + 2)], w[6'(4 * r + 3)]};
    endtask

    task automatic load_keys(input int nr);
        for (int r = 0; r <= nr; r++) begin
            KEY_WE   = 1'b1;
            KEY_IDX  = 4'(r);
            KEY_DATA = rks[4'(r)];
            @(posedge CLK); #1;
        end
        KEY_WE = 1'b0;
    endtask

    // Offers a block and returns just after the accepting edge.
    task automatic start_block(input logic [127:0] ct, input logic hold);
        int n;
        n        = 0;
        IN_DATA  = ct;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 128'(in_ready), 128'(1));
        @(posedge CLK); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input int nr, input int n0,
                               input logic [127:0] exp, input logic drain);
        int   n;
        logic busy_ok;
        n       = n0;
        busy_ok = 1'b1;
        while (!out_valid && n < 60) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge CLK); #1;
            n++;
        end
        check({name, "_latency"}, 128'(n), 128'(nr));
        check({name, "_busy"}, 128'(busy_ok && busy), 128'(1));
        check({name, "_data"}, out_data, exp);
        if (drain) begin
            OUT_READY = 1'b1;
            @(posedge CLK); #1;
            OUT_READY = 1'b0;
            check({name, "_drained"}, 128'(out_valid), 128'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached without completion", $time);
        $fatal(1);
    end

    initial begin
        vec_t vecs [0:2];
        int   nr;
        logic seen;

        vecs[0] = '{name: "fips_c1", sel: 1'b0, nk: 4, key: KEY_C1, ct: CT_C1, pt: PT_STD};
        vecs[1] = '{name: "fips_appb", sel: 1'b0, nk: 4,
                    key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    ct: 128'h3925841d02dc09fbdc118597196a0b32,
                    pt: 128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{name: "fips_c3", sel: 1'b1, nk: 8,
                    key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    ct: 128'h8ea2b7ca516745bfeafc49904b496089, pt: PT_STD};

        RST       = 1'b1;
        KEY_WE    = 1'b0;
        KEY_IDX   = '0;
        KEY_DATA  = '0;
        IN_DATA   = '0;
        OUT_READY = 1'b0;
        in_valid  = 1'b0;
        sel       = 1'b0;
        build_sbox();

        @(posedge CLK); #1;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'(1));

        for (int i = 0; i < 3; i++) begin
            sel = vecs[2'(i)].sel;
            nr  = sel ? 14 : 10;
            expand(vecs[2'(i)].key, vecs[2'(i)].nk, nr);
            load_keys(nr);
            start_block(vecs[2'(i)].ct, 1'b0);
            wait_result(vecs[2'(i)].name, nr, 0, vecs[2'(i)].pt, 1'b1);
        end

        sel = 1'b0;
        expand(KEY_C1, 4, 10);
        load_keys(10);

        // Key write to rk[NR] on the accepting edge must not affect the initial AddRoundKey.
        IN_DATA  = CT_C1;
        in_valid = 1'b1;
        KEY_WE   = 1'b1;
        KEY_IDX  = 4'd10;
        KEY_DATA = '1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        KEY_WE   = 1'b0;
        wait_result("key_write_at_accept", 10, 0, PT_STD, 1'b1);
        KEY_WE   = 1'b1;
        KEY_IDX  = 4'd10;
        KEY_DATA = rks[10];
        @(posedge CLK); #1;
        KEY_WE   = 1'b0;

        // Backpressure: output held while a second block waits.
        start_block(CT_C1, 1'b1);
        wait_result("bp_first", 10, 0, PT_STD, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 128'(out_valid), 128'(1));
            check("bp_hold_data", out_data, PT_STD);
            check("bp_hold_in_ready", 128'(in_ready), 128'(0));
            @(posedge CLK); #1;
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check("bp_after_hs_valid", 128'(out_valid), 128'(0));
        check("bp_after_hs_busy", 128'(busy), 128'(0));
        check("bp_after_hs_in_ready", 128'(in_ready), 128'(1));
        @(posedge CLK); #1;
        in_valid = 1'b0;
        check("bp_second_accepted", 128'(busy), 128'(1));
        wait_result("bp_second", 10, 0, PT_STD, 1'b1);

        // Reset while CNT=5 aborts the block; keys are kept.
        start_block(CT_C1, 1'b0);
        repeat (4) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'(0));
        @(posedge CLK); #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_out_data", out_data, 128'(0));
        RST = 1'b0;
        #1;
        check("midrst_in_ready_release", 128'(in_ready), 128'(1));
        seen = 1'b0;
        repeat (15) begin
            @(posedge CLK); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_output", 128'(seen), 128'(0));
        start_block(CT_C1, 1'b0);
        wait_result("midrst_redo", 10, 0, PT_STD, 1'b1);

        // Illegal key writes: during ROUND, and to an index above NR.
        start_block(CT_C1, 1'b0);
        KEY_WE   = 1'b1;
        KEY_IDX  = 4'd3;
        KEY_DATA = '1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        KEY_WE = 1'b0;
        wait_result("illegal_round_write", 10, 2, PT_STD, 1'b1);
        KEY_WE   = 1'b1;
        KEY_IDX  = 4'd15;
        KEY_DATA = '1;
        @(posedge CLK); #1;
        KEY_WE = 1'b0;
        start_block(CT_C1, 1'b0);
        wait_result("illegal_idx_write", 10, 0, PT_STD, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
